r2sdf_stage_32b: RTL
====================

R2SDF_STAGE_32B -- requirements
Module: r2sdf_stage_32b

Interface
REQ-001 SHALL have parameter DEPTH, default 32, feedback delay depth; a power of two, 1..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  input sample accepted this cycle.
REQ-005 SHALL have port i_data  input  32  sample {real[31:16], imag[15:0]}, each 16-bit two's complement.
REQ-006 SHALL have port o_valid  output  1  o_data valid this cycle.
REQ-007 SHALL have port o_data  output  32  butterfly result, same packing as i_data.
REQ-008 SHALL have port o_sel  output  1  0 = sum output, 1 = difference output.
REQ-009 SHALL have port o_tw_idx  output  5  twiddle index for the downstream multiplier; 0 when o_sel=0.

Function
REQ-010 SHALL implement one radix-2 single-path delay-feedback stage; frame = 2*DEPTH accepted samples.
REQ-011 SHALL keep counter cnt (0..2*DEPTH-1), incremented only on accepted samples (i_valid=1); wraps 2*DEPTH-1 -> 0.
REQ-012 SHALL hold a DEPTH-entry feedback buffer of 32-bit words, addressed by cnt mod DEPTH.
REQ-013 Phase 0 (cnt < DEPTH), accepted sample: SHALL write i_data to buffer[cnt]; output previous buffer[cnt] with o_sel=1, o_tw_idx = cnt.
REQ-014 Phase 1 (cnt >= DEPTH), accepted sample b, a = buffer[cnt-DEPTH]: SHALL output (a+b)>>>1 with o_sel=0, o_tw_idx=0; SHALL write (a-b)>>>1 to buffer[cnt-DEPTH].
REQ-015 Arithmetic SHALL be per component (real, imag independent), 17-bit signed intermediate, arithmetic right shift by 1 (floor); no saturation needed, result always fits 16 bits.
REQ-016 Outputs SHALL be registered; latency exactly 1 cycle from accepted sample to o_valid.
REQ-017 o_valid SHALL be 1 the cycle after every accepted phase-1 sample.
REQ-018 o_valid SHALL be 1 the cycle after an accepted phase-0 sample only when drain_ok=1; drain_ok clears on reset, sets when cnt wraps 2*DEPTH-1 -> 0.
REQ-019 Cycle with i_valid=0 SHALL leave cnt, buffer, drain_ok unchanged; next cycle o_valid=0, o_data/o_sel/o_tw_idx hold.
REQ-020 Stored differences SHALL drain only as the next frame's phase-0 samples are accepted; no internal flush.
REQ-021 DEPTH=1 SHALL work: phases alternate every accepted sample, o_tw_idx always 0.

Reset
REQ-022 On rst_n=0, immediately: cnt=0, drain_ok=0, all buffer words 0, o_valid=0, o_data=0, o_sel=0, o_tw_idx=0.
REQ-023 Reset mid-frame SHALL discard partial frame; after release first DEPTH accepted samples produce o_valid=0.
REQ-024 First accepted sample after rst_n deasserts SHALL be treated as frame index 0.

Verification (DEPTH=4 unless stated)
REQ-025 After reset, stream reals 2,4,6,8,10,12,14,16 (imag 0), i_valid=1 continuously -> o_valid=0 for first 4 outputs; next 4: o_data 0x00060000, 0x00080000, 0x000A0000, 0x000C0000, o_sel=0, o_tw_idx=0.
REQ-026 Continue with a second frame of zeros -> first 4 outputs 0xFFFC0000 each, o_sel=1, o_tw_idx 0,1,2,3, o_valid=1; then 4 sums 0x00000000.
REQ-027 Extremes in real part: a=0x7FFF,b=0x7FFF -> sum 0x7FFF, diff 0x0000; a=0x8000,b=0x8000 -> sum 0x8000; a=0x7FFF,b=0x8000 -> diff 0x7FFF; imag part checked identically.
REQ-028 Scenario REQ-025 with i_valid deasserted on random cycles -> identical o_data sequence on o_valid=1 cycles; o_valid=0 and outputs held during stalls.
REQ-029 rst_n pulsed low at cnt=6 mid second frame -> outputs zero immediately; restart REQ-025 stream -> REQ-025 results exactly.
REQ-030 DEPTH=1, inputs 0x00040002, 0x00020004, 0x00000000 -> outputs (cycle 2) 0x00030003 o_sel=0, (cycle 3) 0x0001FFFF o_sel=1.

Source files
------------

// File: rtl/r2sdf_stage_32b.sv
// Radix-2 single-path delay-feedback butterfly stage for packed complex 16+16-bit samples.
// The feedback buffer holds first-half samples, then the halved differences drained by the next frame.
module r2sdf_stage_32b #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_sel,
    output logic [4:0]  o_tw_idx
);

    localparam int CW = (DEPTH > 1) ? $clog2(2 * DEPTH) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = 2 ** AW;
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * DEPTH - 1);

    logic [CW-1:0] cnt_r;
    logic          drain_ok_r;
    logic [31:0]   buf_r [NB];

    logic [AW-1:0] addr_s;
    logic          phase_s;
    logic [31:0]   rd_s;
    logic [31:0]   sum_s;
    logic [31:0]   diff_s;

    // Halved sum of one 16-bit component; dropping bit 0 of the 17-bit result is a floor shift.
    function automatic logic [15:0] half_sum(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
        return s[16:1];
    endfunction

    // Halved difference of one 16-bit component, same floor behaviour.
    function automatic logic [15:0] half_diff(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] d;
        d = $signed({a[15], a}) - $signed({b[15], b});
        return d[16:1];
    endfunction

    // Buffer addressing and butterfly arithmetic.
    always_comb begin
        addr_s  = {AW{1'b0}};
        if (DEPTH > 1) begin
            addr_s = AW'(cnt_r);
        end else begin
            addr_s = {AW{1'b0}};
        end
        phase_s = cnt_r[CW-1];
        rd_s    = buf_r[addr_s];
        sum_s   = {half_sum(rd_s[31:16], i_data[31:16]), half_sum(rd_s[15:0], i_data[15:0])};
        diff_s  = {half_diff(rd_s[31:16], i_data[31:16]), half_diff(rd_s[15:0], i_data[15:0])};
    end

    // Sample counter and drain permission, which opens once a whole frame has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CW{1'b0}};
            drain_ok_r <= 1'b0;
        end else if (i_valid) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r      <= {CW{1'b0}};
                drain_ok_r <= 1'b1;
            end else begin
                cnt_r      <= cnt_r + CW'(1);
                drain_ok_r <= drain_ok_r;
            end
        end else begin
            cnt_r      <= cnt_r;
            drain_ok_r <= drain_ok_r;
        end
    end

    // Feedback buffer: phase 0 stores the incoming sample, phase 1 stores the halved difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                buf_r[i] <= 32'h0000_0000;
            end
        end else if (i_valid) begin
            if (phase_s) begin
                buf_r[addr_s] <= diff_s;
            end else begin
                buf_r[addr_s] <= i_data;
            end
        end else begin
            buf_r[addr_s] <= buf_r[addr_s];
        end
    end

    // Registered outputs; data, select and twiddle hold across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_data   <= 32'h0000_0000;
            o_sel    <= 1'b0;
            o_tw_idx <= 5'd0;
        end else if (i_valid) begin
            if (phase_s) begin
                o_valid  <= 1'b1;
                o_data   <= sum_s;
                o_sel    <= 1'b0;
                o_tw_idx <= 5'd0;
            end else begin
                o_valid  <= drain_ok_r;
                o_data   <= rd_s;
                o_sel    <= 1'b1;
                o_tw_idx <= 5'(addr_s);
            end
        end else begin
            o_valid  <= 1'b0;
            o_data   <= o_data;
            o_sel    <= o_sel;
            o_tw_idx <= o_tw_idx;
        end
    end

endmodule
